// File: rtl/lbp_host_pkg.sv
// Shared types and constants for the LBP host responder.
// Image geometry, FSM states and the border-pixel test.
package lbp_host_pkg;

    localparam int IMG_DIM    = 128;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int CRD_W      = ADDR_W / 2;
    localparam int LBP_PIXELS = (IMG_DIM - 2) * (IMG_DIM - 2);

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        SERVE,
        DONE
    } state_t;

    // True when {row, col} lies on the outer ring of the image.
    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        logic [CRD_W-1:0] r;
        logic [CRD_W-1:0] c;
        r = a[ADDR_W-1:CRD_W];
        c = a[CRD_W-1:0];
        return (r == '0) || (c == '0) ||
               (r == CRD_W'(IMG_DIM - 1)) ||
               (c == CRD_W'(IMG_DIM - 1));
    endfunction

endpackage

// File: rtl/lbp_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of an address written at the same edge returns old data.
module lbp_dp_ram #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read that holds its value while re is low.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/lbp_host.sv
// Memory-side responder for the LBP engine gray/lbp interface.
// Clears results, loads the image, serves reads, captures results.
module lbp_host
    import lbp_host_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] result_count,
    output logic              done,
    output logic              border_err,
    output logic              proto_err
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_q;
    logic              gray_we;
    logic              gray_re;
    logic              lbp_hit;
    logic              lbp_ok;
    logic              res_we;
    logic [ADDR_W-1:0] res_waddr;
    logic [DATA_W-1:0] res_wdata;

    // State register and result-clear sweep counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) clr_q <= clr_q + 1'b1;
        end
    end

    // Next-state: sweep, then load, then serve until finish.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (clr_q == '1) state_d = LOAD;
            LOAD:  if (load_done)   state_d = SERVE;
            SERVE: if (finish)      state_d = DONE;
            DONE:  state_d = DONE;
            default: state_d = CLEAR;
        endcase
    end

    // State-decoded outputs and memory port steering.
    always_comb begin
        gray_ready = (state_q == SERVE);
        done       = (state_q == DONE);
        gray_we    = load_en  && (state_q == LOAD);
        gray_re    = gray_req && (state_q == SERVE);
        lbp_hit    = lbp_valid && (state_q == SERVE);
        lbp_ok     = lbp_hit && !is_border(lbp_addr);
        res_we     = (state_q == CLEAR) || lbp_ok;
        res_waddr  = (state_q == CLEAR) ? clr_q : lbp_addr;
        res_wdata  = (state_q == CLEAR) ? '0 : lbp_data;
    end

    // Accepted-write counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_count <= '0;
            border_err   <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (lbp_ok) result_count <= result_count + 1'b1;
            if (lbp_hit && !lbp_ok) border_err <= 1'b1;
            if ((gray_req || lbp_valid) && (state_q != SERVE))
                proto_err <= 1'b1;
        end
    end

    lbp_dp_ram #(.AW(ADDR_W), .DW(DATA_W)) u_gray (
        .clk   (clk),
        .reset (reset),
        .we    (gray_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (gray_re),
        .raddr (gray_addr),
        .rdata (gray_data)
    );

    lbp_dp_ram #(.AW(ADDR_W), .DW(DATA_W)) u_res (
        .clk   (clk),
        .reset (reset),
        .we    (res_we),
        .waddr (res_waddr),
        .wdata (res_wdata),
        .re    (1'b1),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lbp_host.sv
// Self-checking bench for lbp_host.
// Reference model: plain arrays of image and result contents.
module tb_lbp_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [13:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        load_done = 1'b0;
    logic        gray_ready;
    logic        gray_req = 1'b0;
    logic [13:0] gray_addr = '0;
    logic [7:0]  gray_data;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic [13:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic [13:0] result_count;
    logic        done;
    logic        border_err;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] gray_ref [16384];
    logic [7:0] res_ref  [16384];
    int         cnt = 0;
    logic [7:0] exp_gray = '0;
    logic       exp_berr = 1'b0;
    logic [6:0] crd [5] = '{7'd0, 7'd1, 7'd63, 7'd126, 7'd127};

    lbp_host dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_done(load_done),
        .gray_ready(gray_ready), .gray_req(gray_req),
        .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .result_count(result_count), .done(done),
        .border_err(border_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit on_border(input int a);
        int r = a / 128;
        int c = a % 128;
        return (r == 0) || (r == 127) || (c == 0) || (c == 127);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL reset_gray_ready got %b want 0", gray_ready); end
        checks++; if (gray_data !== 8'h00) begin errors++; $display("FAIL reset_gray_data got %h want 00", gray_data); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        checks++; if (result_count !== 14'd0) begin errors++; $display("FAIL reset_count got %0d want 0", result_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (border_err !== 1'b0) begin errors++; $display("FAIL reset_border_err got %b want 0", border_err); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
        reset = 1'b0;
    endtask

    task automatic test_clear();
        int bad = 0;
        for (int i = 0; i < 16384; i++) begin
            res_ref[i] = 8'h00;
            tick();
            if (gray_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_gray_ready high cycles got %0d want 0", bad); end
        rd_addr = 14'd0;     tick();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL clear_rd0 got %h want 00", rd_data); end
        rd_addr = 14'd129;   tick();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL clear_rd129 got %h want 00", rd_data); end
        rd_addr = 14'd16383; tick();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL clear_rd16383 got %h want 00", rd_data); end
        checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL load_gray_ready got %b want 0", gray_ready); end
    endtask

    task automatic test_load();
        for (int a = 0; a < 16384; a++) begin
            load_en   = 1'b1;
            load_addr = 14'(a);
            load_data = (a == 16383) ? 8'h5A : 8'(a);
            load_done = (a == 16383);
            gray_ref[a] = load_data;
            if (a == 16383) begin
                checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL pre_done_gray_ready got %b want 0", gray_ready); end
            end
            tick();
        end
        load_en = 1'b0;
        load_done = 1'b0;
        checks++; if (gray_ready !== 1'b1) begin errors++; $display("FAIL post_done_gray_ready got %b want 1", gray_ready); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL load_proto_err got %b want 0", proto_err); end
    endtask

    task automatic test_serve();
        logic [13:0] seq [5] = '{14'h0102, 14'd5, 14'd6, 14'd7, 14'd16383};
        gray_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            gray_addr = seq[i];
            exp_gray = gray_ref[seq[i]];
            tick();
            checks++; if (gray_data !== exp_gray) begin errors++; $display("FAIL serve_seq addr %h got %h want %h", seq[i], gray_data, exp_gray); end
        end
        load_en = 1'b1; load_addr = 14'd5; load_data = 8'hEE;
        gray_addr = 14'd5; exp_gray = gray_ref[5];
        tick();
        load_en = 1'b0;
        tick();
        checks++; if (gray_data !== 8'h05) begin errors++; $display("FAIL serve_load_ignored got %h want 05", gray_data); end
        for (int i = 0; i < 30; i++) begin
            gray_req = 1'($urandom_range(0, 1));
            gray_addr = 14'($urandom);
            if (gray_req) exp_gray = gray_ref[gray_addr];
            tick();
            checks++; if (gray_data !== exp_gray) begin errors++; $display("FAIL serve_rand addr %h got %h want %h", gray_addr, gray_data, exp_gray); end
        end
        gray_req = 1'b0;
    endtask

    task automatic test_border();
        logic [13:0] ba [5];
        ba[0] = {7'd0, 7'd5};
        ba[1] = {7'd127, 7'(1 + $urandom_range(0, 125))};
        ba[2] = {7'(1 + $urandom_range(0, 125)), 7'd0};
        ba[3] = {7'(1 + $urandom_range(0, 125)), 7'd127};
        ba[4] = {7'd127, 7'd127};
        for (int i = 0; i < 5; i++) begin
            lbp_valid = 1'b1; lbp_addr = ba[i]; lbp_data = 8'hFF;
            tick();
            checks++; if (border_err !== 1'b1) begin errors++; $display("FAIL border_err addr %h got %b want 1", ba[i], border_err); end
            checks++; if (result_count !== 14'd0) begin errors++; $display("FAIL border_count got %0d want 0", result_count); end
        end
        exp_berr = 1'b1;
        lbp_valid = 1'b0;
        rd_addr = 14'd5;
        tick();
        tick();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL border_rd5 got %h want 00", rd_data); end
    endtask

    task automatic test_full_run();
        int k = 0;
        int bad = 0;
        logic [7:0] exp_rd;
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                lbp_valid = 1'b1;
                lbp_addr = {7'(r), 7'(c)};
                lbp_data = (k == 0) ? 8'hA5 : 8'($urandom);
                finish = (k == 15875);
                rd_addr = (k < 2) ? 14'd129 : 14'($urandom);
                exp_rd = res_ref[rd_addr];
                res_ref[lbp_addr] = lbp_data;
                cnt++;
                if (k == 15875) begin
                    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pre_finish_done got %b want 0", done); end
                end
                tick();
                if (k < 2) begin
                    checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL run_rd129 k=%0d got %h want %h", k, rd_data, exp_rd); end
                    checks++; if (result_count !== 14'(cnt)) begin errors++; $display("FAIL run_count k=%0d got %0d want %0d", k, result_count, cnt); end
                end else if (rd_data !== exp_rd || result_count !== 14'(cnt)) begin
                    bad++;
                end
                k++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL run_stream bad cycles got %0d want 0", bad); end
        checks++; if (result_count !== 14'd15876) begin errors++; $display("FAIL run_total got %0d want 15876", result_count); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done got %b want 1", done); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL run_proto_err got %b want 0", proto_err); end
        finish = 1'b0;
        lbp_addr = 14'd129; lbp_data = 8'h33;
        gray_req = 1'b1; gray_addr = 14'd6;
        tick();
        lbp_valid = 1'b0; gray_req = 1'b0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL done_proto_err got %b want 1", proto_err); end
        checks++; if (result_count !== 14'd15876) begin errors++; $display("FAIL done_count got %0d want 15876", result_count); end
        checks++; if (gray_data !== exp_gray) begin errors++; $display("FAIL done_gray_hold got %h want %h", gray_data, exp_gray); end
        for (int i = 0; i < 40; i++) begin
            rd_addr = (i == 0) ? 14'd129 : 14'($urandom);
            tick();
            checks++; if (rd_data !== res_ref[rd_addr]) begin errors++; $display("FAIL done_rd addr %h got %h want %h", rd_addr, rd_data, res_ref[rd_addr]); end
        end
    endtask

    task automatic test_restart();
        int bad = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0; exp_gray = 8'h00; exp_berr = 1'b0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL restart_proto_err got %b want 0", proto_err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", done); end
        checks++; if (result_count !== 14'd0) begin errors++; $display("FAIL restart_count got %0d want 0", result_count); end
        for (int i = 0; i < 16384; i++) begin
            res_ref[i] = 8'h00;
            load_en = (i < 64);
            load_addr = 14'h0102; load_data = 8'hEE;
            tick();
            if (gray_ready !== 1'b0) bad++;
        end
        load_en = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL restart_clear_ready got %0d want 0", bad); end
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        checks++; if (gray_ready !== 1'b1) begin errors++; $display("FAIL restart_gray_ready got %b want 1", gray_ready); end
        gray_req = 1'b1; gray_addr = 14'h0102;
        exp_gray = gray_ref[14'h0102];
        tick();
        gray_req = 1'b0;
        checks++; if (gray_data !== 8'h02) begin errors++; $display("FAIL restart_retained got %h want 02", gray_data); end
    endtask

    task automatic test_random_traffic();
        logic [7:0] exp_rd;
        for (int i = 0; i < 300; i++) begin
            lbp_valid = 1'($urandom_range(0, 1));
            lbp_addr = {crd[$urandom_range(0, 4)], crd[$urandom_range(0, 4)]};
            lbp_data = 8'($urandom);
            rd_addr = {crd[$urandom_range(0, 4)], crd[$urandom_range(0, 4)]};
            gray_req = 1'($urandom_range(0, 1));
            gray_addr = 14'($urandom);
            exp_rd = res_ref[rd_addr];
            if (gray_req) exp_gray = gray_ref[gray_addr];
            if (lbp_valid) begin
                if (on_border(int'(lbp_addr))) exp_berr = 1'b1;
                else begin res_ref[lbp_addr] = lbp_data; cnt++; end
            end
            tick();
            checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rand_rd addr %h got %h want %h", rd_addr, rd_data, exp_rd); end
            checks++; if (gray_data !== exp_gray) begin errors++; $display("FAIL rand_gray got %h want %h", gray_data, exp_gray); end
            checks++; if (result_count !== 14'(cnt)) begin errors++; $display("FAIL rand_count got %0d want %0d", result_count, cnt); end
            checks++; if (border_err !== exp_berr) begin errors++; $display("FAIL rand_border got %b want %b", border_err, exp_berr); end
        end
        lbp_valid = 1'b0; gray_req = 1'b0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rand_proto_err got %b want 0", proto_err); end
    endtask

    task automatic test_mid_serve_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL mid_gray_ready got %b want 0", gray_ready); end
        checks++; if (gray_data !== 8'h00) begin errors++; $display("FAIL mid_gray_data got %h want 00", gray_data); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data got %h want 00", rd_data); end
        checks++; if (result_count !== 14'd0) begin errors++; $display("FAIL mid_count got %0d want 0", result_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
        checks++; if (border_err !== 1'b0) begin errors++; $display("FAIL mid_border_err got %b want 0", border_err); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_proto_err got %b want 0", proto_err); end
        gray_req = 1'b1; gray_addr = 14'd5;
        tick();
        gray_req = 1'b0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL clear_req_proto_err got %b want 1", proto_err); end
        checks++; if (gray_data !== 8'h00) begin errors++; $display("FAIL clear_req_gray_data got %h want 00", gray_data); end
        checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL clear_req_gray_ready got %b want 0", gray_ready); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_load();
        test_serve();
        test_border();
        test_full_run();
        test_restart();
        test_random_traffic();
        test_mid_serve_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lbp_host.md
# lbp_host

Memory-side responder for the LBP engine's gray/lbp interface. It holds one 128×128 8-bit gray image loaded by the system, serves the engine's gray-pixel reads, and captures the engine's LBP result writes into a result memory with readback. It also tracks completion and protocol errors. It sits between the system loader/reader and the LBP engine, in place of a testbench memory model.

## Interface
- `IMG_DIM`, 128: image side length, a power of two.
- `ADDR_W`, 14: pixel address width, log2(IMG_DIM²). The address is {row[6:0], col[6:0]}.
- `DATA_W`, 8: pixel width.

Ports, one per line:
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_en` in 1: image write strobe.
- `load_addr` in ADDR_W: image write address.
- `load_data` in DATA_W: image write data.
- `load_done` in 1: image complete; pulse.
- `gray_ready` out 1: image available to the engine.
- `gray_req` in 1: engine read request.
- `gray_addr` in ADDR_W: engine read address.
- `gray_data` out DATA_W: read data.
- `lbp_valid` in 1: engine result write strobe.
- `lbp_addr` in ADDR_W: result address.
- `lbp_data` in DATA_W: result value.
- `finish` in 1: engine done.
- `rd_addr` in ADDR_W: result readback address.
- `rd_data` out DATA_W: readback data.
- `result_count` out ADDR_W: number of accepted result writes.
- `done` out 1: finish was seen.
- `border_err` out 1: sticky; a write targeted a border pixel.
- `proto_err` out 1: sticky; `gray_req` or `lbp_valid` arrived outside SERVE.

Reset is synchronous active-high. Clock is `clk`, reset is `reset`.

## Operation
States: CLEAR → LOAD → SERVE → DONE.

- **CLEAR.** Entered on reset. A 14-bit sweep counter writes 0 to every result location, one per cycle, 16384 cycles. After the write to address 16383 the block goes to LOAD. `load_en` is ignored in CLEAR.
- **LOAD.** On `load_en`, `gray_mem[load_addr] <= load_data`. On `load_done`, go to SERVE. If `load_en` and `load_done` arrive in the same cycle, the write is performed and the block still moves to SERVE.
- **SERVE.**
  - On `gray_req`: `gray_data <= gray_mem[gray_addr]`. With `gray_req` low, `gray_data` holds its value.
  - On `lbp_valid`: if row or col is 0 or 127, suppress the write and set `border_err`. Otherwise `res_mem[lbp_addr] <= lbp_data` and `result_count` increments. Rewrites to the same address overwrite and count again.
  - On `finish`: go to DONE. A `lbp_valid` in the same cycle as `finish` is still captured and counted.
- **DONE.** Terminal until reset. `done`=1. `result_count` is frozen. `gray_data` holds.
- **Protocol errors.** `gray_req` or `lbp_valid` in CLEAR, LOAD or DONE is ignored and sets `proto_err`.
- **Readback.** `rd_data <= res_mem[rd_addr]` every cycle, in all states.
- **Border pixels** therefore always read back 0 after CLEAR.
- **Reset mid-operation.** All outputs and flags return to their reset values and the block re-enters CLEAR. `gray_mem` contents are retained but unusable until a new `load_done`.

## Timing
- Reset values: `gray_ready`=0, `gray_data`=0, `rd_data`=0, `result_count`=0, `done`=0, `border_err`=0, `proto_err`=0.
- `gray_ready` and `done` are decoded from the registered state.
  - `gray_ready` rises the cycle after `load_done` is sampled.
  - `done` rises the cycle after `finish` is sampled.
- `gray_data` has 1-cycle latency: address at edge N, data valid after edge N, sampled by the engine at edge N+1. Back-to-back requests give one datum per cycle.
- Result write, `result_count` increment and error flags all update at the sampling edge.
- Readback has 1-cycle latency. A read of an address written at the same edge returns the old data; the new value is visible one cycle later.
- CLEAR lasts exactly 16384 cycles after reset deassertion. LOAD is entered at cycle 16384.
- `result_count` is 14-bit and does not saturate. A full run gives 126×126 = 15876.

## Structure
- Package `lbp_host_pkg`: `IMG_DIM`, `ADDR_W`, `DATA_W`, `LBP_PIXELS` = 15876, the state enum {CLEAR, LOAD, SERVE, DONE}, and the border-test function on {row, col}.
- One sub-module, `lbp_dp_ram`: one write port, one registered read port, read-during-write returns old data. Instantiated twice:
  - gray memory: write from load, read from gray.
  - result memory: write mux of clear-sweep / lbp, read from readback.

## Test plan
- **Reset and clear.** Reset, wait 16384 cycles → LOAD entered, `gray_ready`=0; reads of `rd_addr` 0, 129 and 16383 return 0.
- **Load and serve.** Load `mem[a]` = a[7:0]; `load_done`; `gray_req` with `gray_addr`=0x0102 → `gray_ready`=1 the cycle after `load_done`; next cycle `gray_data`=0x02; back-to-back addresses 5, 6, 7 → 0x05, 0x06, 0x07 on consecutive cycles.
- **Interior write.** `lbp_valid` with `lbp_addr`={1,1}, `lbp_data`=0xA5 → `result_count`=1; readback of 129 gives 0xA5; a same-edge read returns 0.
- **Border write.** `lbp_valid` with `lbp_addr`={0,5}, data 0xFF → `border_err`=1, count unchanged, readback 5 gives 0.
- **Full run.** Drive 15876 interior writes with the last one in the same cycle as `finish` → `result_count`=15876, `done`=1 the next cycle; a further `lbp_valid` sets `proto_err` and the count stays at 15876.
- **Mid-SERVE reset.** Assert `reset` during SERVE → next cycle all outputs are 0, state is CLEAR; `gray_req` during CLEAR sets `proto_err`.
